// File: rtl/sha_block_sequencer.sv
// Streaming SHA-256 padder: packs message bytes into 512-bit blocks, appends the 0x80 marker,
// zero fill and 64-bit big-endian bit length, and emits blocks over a valid/ready handshake.
module sha_block_sequencer #(
    parameter int LEN_W      = 32,
    parameter int BLOCK_BITS = 512  // must be 512; byte indexing below assumes 64-byte blocks
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [BLOCK_BITS-1:0] blk_data,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic                  blk_first,
    output logic                  blk_last
);

    typedef enum logic [2:0] {
        FILL,
        EMIT_MID,
        EMIT_PRE,
        EMIT_FINAL,
        EXTRA
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              ptr_q, ptr_d, ptr_inc;
    logic [LEN_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                    first_q, first_d;
    logic                    pend_q, pend_d;
    logic [BLOCK_BITS-1:0]   buf_q, buf_d;
    logic [63:0]             len_inc, len_cur;

    assign ptr_inc = ptr_q + 6'd1;
    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        len_inc = '0;
        len_cur = '0;
        len_inc[LEN_W+2:0] = {cnt_inc, 3'b000};
        len_cur[LEN_W+2:0] = {cnt_q, 3'b000};
    end

    // Byte position p lives at bits {~p,3'b000} +: 8, i.e. byte 0 in the top byte lane.
    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        pend_d    = pend_q;
        buf_d     = buf_q;
        s_ready   = 1'b0;
        blk_valid = 1'b0;

        case (state_q)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    buf_d[{~ptr_q, 3'b000} +: 8] = s_data;
                    ptr_d = ptr_inc;
                    cnt_d = cnt_inc;
                    if (s_last) begin
                        if (ptr_q != 6'd63) begin
                            buf_d[{~ptr_inc, 3'b000} +: 8] = 8'h80;
                        end
                        if (ptr_q <= 6'd54) begin
                            buf_d[63:0] = len_inc;
                            state_d     = EMIT_FINAL;
                        end else begin
                            pend_d  = (ptr_q == 6'd63);
                            state_d = EMIT_PRE;
                        end
                    end else if (ptr_q == 6'd63) begin
                        state_d = EMIT_MID;
                    end
                end
            end

            EMIT_MID, EMIT_PRE, EMIT_FINAL: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    buf_d   = '0;
                    ptr_d   = '0;
                    first_d = 1'b0;
                    case (state_q)
                        EMIT_MID: state_d = FILL;
                        EMIT_PRE: state_d = EXTRA;
                        default: begin
                            state_d = FILL;
                            cnt_d   = '0;
                            first_d = 1'b1;
                        end
                    endcase
                end
            end

            EXTRA: begin
                buf_d = '0;
                if (pend_q) begin
                    buf_d[BLOCK_BITS-1 -: 8] = 8'h80;
                end
                buf_d[63:0] = len_cur;
                pend_d      = 1'b0;
                state_d     = EMIT_FINAL;
            end

            default: state_d = FILL;
        endcase
    end

    // NOTE: the block buffer is plain flops (not a RAM), so resetting it is cheap and keeps
    // blk_data at zero out of reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            ptr_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            pend_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
        end
    end

    assign blk_data  = buf_q;
    assign blk_first = blk_valid & first_q;
    assign blk_last  = (state_q == EMIT_FINAL);

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Self-checking bench for sha_block_sequencer: table-driven messages, reset corner cases and
// random messages compared against a padding model built from whole-message byte queues.
module tb_sha_block_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    always #5 clk = ~clk;

    sha_block_sequencer #(.LEN_W(32), .BLOCK_BITS(512)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [511:0] data;
        bit           first;
        bit           last;
        bit           pre;   // next block is the padding-only extra block
    } blk_t;

    typedef struct {
        int          len;
        bit          abc;
        logic [7:0]  pat;
        int          stall;
        int          nblk;
        logic [63:0] flen;
    } vec_t;

    logic [7:0]   msg[$];
    blk_t         exp_q[$];
    int           rx_cnt;
    logic [63:0]  last_len;
    logic [511:0] first_rx;

    // Reference: pad the whole message as a byte list, then cut it into 64-byte blocks.
    function automatic void build_expected();
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          nb;
        blk_t        b;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nb = p.size() / 64;
        exp_q.delete();
        for (int j = 0; j < nb; j++) begin
            b.data = '0;
            for (int i = 0; i < 64; i++) b.data[511-8*i -: 8] = p[j*64+i];
            b.first = (j == 0);
            b.last  = (j == nb - 1);
            b.pre   = (j == nb - 2) && (msg.size() <= (nb - 1) * 64);
            exp_q.push_back(b);
        end
    endfunction

    task automatic drive_msg(input bit gaps);
        bit acc;
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == msg.size() - 1);
            acc = 1'b0;
            for (int c = 0; c < 2000 && !acc; c++) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk); #1;
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (!acc) begin
                check("byte_accept_timeout", 0, 1);
                break;
            end
            if ((i % 64) == 63 || i == msg.size() - 1) begin
                check("blk_valid_latency", blk_valid, 1);
                check("s_ready_stall", s_ready, 0);
            end
        end
    endtask

    // stall < 0 picks a random 0..2 stall per block.
    task automatic collect(input int stall, input int budget);
        int           st, cur_stall, pre_wait;
        bit           have_ref;
        logic [511:0] ref_data;
        logic         ref_first, ref_last;
        blk_t         e;
        st = 0; pre_wait = 0; have_ref = 0;
        ref_data = '0; ref_first = 0; ref_last = 0;
        cur_stall = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (pre_wait == 2) begin
                check("extra_gap_idle", blk_valid, 0);
                pre_wait = 1;
            end else if (pre_wait == 1) begin
                check("extra_gap_valid", blk_valid, 1);
                pre_wait = 0;
            end
            if (blk_valid) begin
                if (!have_ref) begin
                    ref_data = blk_data; ref_first = blk_first; ref_last = blk_last;
                    have_ref = 1;
                end else begin
                    check("stall_data_stable", blk_data, ref_data);
                    check("stall_first_stable", blk_first, ref_first);
                    check("stall_last_stable", blk_last, ref_last);
                    check("stall_s_ready", s_ready, 0);
                end
                if (st < cur_stall) begin
                    blk_ready = 1'b0;
                    st++;
                end else begin
                    blk_ready = 1'b1;
                    e = exp_q.pop_front();
                    check("blk_data", blk_data, e.data);
                    check("blk_first", blk_first, e.first);
                    check("blk_last", blk_last, e.last);
                    if (rx_cnt == 0) first_rx = blk_data;
                    if (e.pre) pre_wait = 2;
                    last_len = blk_data[63:0];
                    rx_cnt++;
                    have_ref = 0;
                    st = 0;
                    cur_stall = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
                end
            end else begin
                blk_ready = 1'($urandom_range(0, 1));
            end
        end
        if (exp_q.size() > 0) check("block_timeout", exp_q.size(), 0);
    endtask

    task automatic run_msg(input int stall, input bit gaps);
        build_expected();
        rx_cnt = 0;
        last_len = '0;
        fork
            drive_msg(gaps);
            collect(stall, 1000 + msg.size() * 12);
        join
        @(posedge clk); #1;
        check("no_extra_block", blk_valid, 0);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{len: 3,   abc: 1, pat: 8'h00, stall: 0, nblk: 1, flen: 64'h18};
        tbl[1] = '{len: 55,  abc: 0, pat: 8'h00, stall: 0, nblk: 1, flen: 64'h1B8};
        tbl[2] = '{len: 56,  abc: 0, pat: 8'hAA, stall: 0, nblk: 2, flen: 64'h1C0};
        tbl[3] = '{len: 64,  abc: 0, pat: 8'h11, stall: 0, nblk: 2, flen: 64'h200};
        tbl[4] = '{len: 130, abc: 0, pat: 8'h5A, stall: 5, nblk: 3, flen: 64'h410};

        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; blk_ready = 1'b0;
        first_rx = '0;
        #12;
        check("rst_blk_valid", blk_valid, 0);
        check("rst_blk_first", blk_first, 0);
        check("rst_blk_last", blk_last, 0);
        check("rst_blk_data", blk_data, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_s_ready", s_ready, 1);

        foreach (tbl[t]) begin
            msg.delete();
            for (int i = 0; i < tbl[t].len; i++)
                msg.push_back(tbl[t].abc ? 8'(8'h61 + i) : tbl[t].pat);
            run_msg(tbl[t].stall, 1'b0);
            check($sformatf("tbl%0d_blocks", t), rx_cnt, tbl[t].nblk);
            check($sformatf("tbl%0d_len", t), last_len, tbl[t].flen);
            if (tbl[t].abc) check("abc_block", first_rx, {32'h61626380, 416'b0, 64'h18});
        end

        // Reset while a block is waiting on the handshake.
        blk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h61 + i); s_last = (i == 2);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        check("hs_pending_valid", blk_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("hs_rst_valid", blk_valid, 0);
        check("hs_rst_data", blk_data, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset after 30 bytes of a message, then "abc" must come out as a fresh message.
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1; s_data = 8'(i + 1); s_last = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("abort_no_block", blk_valid, 0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_s_ready", s_ready, 1);
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(0, 1'b0);
        check("abort_abc_blocks", rx_cnt, 1);
        check("abort_abc_block", first_rx, {32'h61626380, 416'b0, 64'h18});

        // Random messages with random input gaps and output stalls.
        for (int r = 0; r < 25; r++) begin
            int n;
            int nexp;
            msg.delete();
            n = (r < 4) ? 62 + r : int'($urandom_range(1, 200));
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            nexp = (n + 8) / 64 + 1;
            run_msg(-1, 1'b1);
            check($sformatf("rand%0d_blocks", r), rx_cnt, nexp);
            check($sformatf("rand%0d_len", r), last_len, 64'(n) * 64'd8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
